addsub_pipe: RTL and testbench

ADDSUB_PIPE -- requirements
Module: addsub_pipe

---
 rtl/addsub_pipe.sv | 133 +++++++++++++
 tb/tb_addsub_pipe.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe.sv
// addsub_pipe: two-stage split-carry adder/subtractor with a valid/ready handshake on both sides.
// Optional build macro ADDSUB_PIPE_SAT_EN adds a 'sat' input that clamps overflowed results.
module addsub_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef ADDSUB_PIPE_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int H = WIDTH / 2;

    logic [WIDTH-1:0] b_eff_s;
    logic             cin_eff_s;
    logic [H:0]       lo_s;

    logic             s1_valid_r;
    logic [H-1:0]     s1_lo_r;
    logic             s1_carry_r;
    logic [H-1:0]     s1_a_hi_r;
    logic [H-1:0]     s1_b_hi_r;
    logic             s1_op_r;
`ifdef ADDSUB_PIPE_SAT_EN
    logic             s1_sat_r;
`endif

    logic [H:0]       hi_s;
    logic [WIDTH-1:0] raw_s;
    logic [WIDTH-1:0] res_s;
    logic             cout_s;
    logic             ovf_s;
    logic             s2_adv_s;

    logic             out_valid_r;
    logic [WIDTH-1:0] sum_r;
    logic             c_out_r;
    logic             ovf_r;

    assign s2_adv_s  = !out_valid_r || out_ready;
    assign in_ready  = !s1_valid_r || s2_adv_s;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign c_out     = c_out_r;
    assign ovf       = ovf_r;

    // Stage 1 low half: subtract is a + ~b + !borrow_in.
    always_comb begin
        b_eff_s   = b;
        cin_eff_s = c_in;
        if (op) begin
            b_eff_s   = ~b;
            cin_eff_s = ~c_in;
        end else begin
            b_eff_s   = b;
            cin_eff_s = c_in;
        end
        lo_s = {1'b0, a[H-1:0]} + {1'b0, b_eff_s[H-1:0]} + {{H{1'b0}}, cin_eff_s};
    end

    // Stage 2 upper half, flags and optional clamp; borrow-out is the inverted adder carry.
    always_comb begin
        hi_s   = {1'b0, s1_a_hi_r} + {1'b0, s1_b_hi_r} + {{H{1'b0}}, s1_carry_r};
        raw_s  = {hi_s[H-1:0], s1_lo_r};
        cout_s = s1_op_r ? ~hi_s[H] : hi_s[H];
        ovf_s  = (s1_a_hi_r[H-1] == s1_b_hi_r[H-1]) && (raw_s[WIDTH-1] != s1_a_hi_r[H-1]);
        res_s  = raw_s;
`ifdef ADDSUB_PIPE_SAT_EN
        if (s1_sat_r && ovf_s) begin
            res_s = s1_a_hi_r[H-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            res_s = raw_s;
        end
`endif
    end

    // Stage 1 register: captures operands only on an accepted handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_lo_r    <= {H{1'b0}};
            s1_carry_r <= 1'b0;
            s1_a_hi_r  <= {H{1'b0}};
            s1_b_hi_r  <= {H{1'b0}};
            s1_op_r    <= 1'b0;
`ifdef ADDSUB_PIPE_SAT_EN
            s1_sat_r   <= 1'b0;
`endif
        end else if (in_ready) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_lo_r    <= lo_s[H-1:0];
                s1_carry_r <= lo_s[H];
                s1_a_hi_r  <= a[WIDTH-1:H];
                s1_b_hi_r  <= b_eff_s[WIDTH-1:H];
                s1_op_r    <= op;
`ifdef ADDSUB_PIPE_SAT_EN
                s1_sat_r   <= sat;
`endif
            end
        end
    end

    // Stage 2 / output register: holds the result until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            sum_r       <= {WIDTH{1'b0}};
            c_out_r     <= 1'b0;
            ovf_r       <= 1'b0;
        end else if (s2_adv_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                sum_r   <= res_s;
                c_out_r <= cout_s;
                ovf_r   <= ovf_s;
            end
        end
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed testbench for addsub_pipe (WIDTH=8); saturation checks compile in with ADDSUB_PIPE_SAT_EN.
module tb_addsub_pipe;

    localparam int WIDTH = 8;
    localparam int NV    = 7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
`ifdef ADDSUB_PIPE_SAT_EN
    logic             sat;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t vecs [NV];

    addsub_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef ADDSUB_PIPE_SAT_EN
        .sat       (sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input vec_t v);
        op       = v.op;
        a        = v.a;
        b        = v.b;
        c_in     = v.cin;
        in_valid = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            op    a      b      cin   sum    co    ov
        vecs[0] = '{1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 8'h03, 8'h05, 1'b1, 8'hFD, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 8'h40, 8'h40, 1'b1, 8'h81, 1'b0, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        c_in      = 1'b0;
`ifdef ADDSUB_PIPE_SAT_EN
        sat       = 1'b0;
`endif
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, 8'h00);
        chk("rst_c_out", c_out, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // first edge after release accepts; result shows two edges later
        rst_n = 1'b1;
        drv('{1'b0, 8'h35, 8'h12, 1'b1, 8'h00, 1'b0, 1'b0});
        #1;
        chk("add_in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        a        = 8'hEE;
        #1;
        chk("add_lat1_valid", out_valid, 1'b0);
        tick();
        #1;
        chk("add_lat2_valid", out_valid, 1'b1);
        chk("add_sum", sum, 8'h48);
        chk("add_c_out", c_out, 1'b0);
        chk("add_ovf", ovf, 1'b0);
        tick();
        #1;
        chk("add_drained", out_valid, 1'b0);

        // back-to-back stream, one result per cycle
        for (int i = 0; i <= NV + 1; i++) begin
            if (i < NV) begin
                drv(vecs[i]);
            end else begin
                in_valid = 1'b0;
                op       = 1'b1;
                a        = 8'hA5;
                b        = 8'h5A;
            end
            #1;
            chk("stream_in_ready", in_ready, 1'b1);
            if (i >= 2) begin
                chk("stream_valid", out_valid, 1'b1);
                chk("stream_sum", sum, vecs[i-2].s);
                chk("stream_c_out", c_out, vecs[i-2].co);
                chk("stream_ovf", ovf, vecs[i-2].ov);
            end
            tick();
        end
        #1;
        chk("stream_drained", out_valid, 1'b0);

        // backpressure: consumer stalls for five edges
        out_ready = 1'b0;
        drv('{1'b0, 8'h01, 8'h20, 1'b0, 8'h00, 1'b0, 1'b0});
        #1;
        chk("bp_rdy_1", in_ready, 1'b1);
        tick();
        a = 8'h02;
        #1;
        chk("bp_rdy_2", in_ready, 1'b1);
        tick();
        a = 8'h03;
        #1;
        chk("bp_rdy_low", in_ready, 1'b0);
        chk("bp_hold_valid", out_valid, 1'b1);
        chk("bp_hold_sum", sum, 8'h21);
        tick();
        a = 8'h09;
        #1;
        chk("bp_rdy_low2", in_ready, 1'b0);
        chk("bp_hold_sum2", sum, 8'h21);
        tick();
        #1;
        chk("bp_rdy_low3", in_ready, 1'b0);
        chk("bp_hold_sum3", sum, 8'h21);
        tick();
        a         = 8'h03;
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_release", in_ready, 1'b1);
        chk("bp_out1", sum, 8'h21);
        tick();
        a = 8'h04;
        #1;
        chk("bp_out2_valid", out_valid, 1'b1);
        chk("bp_out2", sum, 8'h22);
        tick();
        in_valid = 1'b0;
        #1;
        chk("bp_out3", sum, 8'h23);
        tick();
        #1;
        chk("bp_out4_valid", out_valid, 1'b1);
        chk("bp_out4", sum, 8'h24);
        tick();
        #1;
        chk("bp_drained", out_valid, 1'b0);

        // reset asserted with both stages full
        out_ready = 1'b0;
        drv('{1'b0, 8'h01, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0});
        tick();
        a = 8'h02;
        b = 8'h02;
        tick();
        in_valid = 1'b0;
        #1;
        chk("mid_full_valid", out_valid, 1'b1);
        chk("mid_full_rdy", in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_sum", sum, 8'h00);
        chk("mid_rst_rdy", in_ready, 1'b1);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("mid_no_stale", out_valid, 1'b0);
            tick();
        end

        drv('{1'b0, 8'h11, 8'h22, 1'b0, 8'h00, 1'b0, 1'b0});
        tick();
        in_valid = 1'b0;
        tick();
        #1;
        chk("post_rst_valid", out_valid, 1'b1);
        chk("post_rst_sum", sum, 8'h33);
        tick();

`ifdef ADDSUB_PIPE_SAT_EN
        sat = 1'b1;
        drv('{1'b1, 8'h80, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0});
        tick();
        in_valid = 1'b0;
        tick();
        #1;
        chk("sat_valid", out_valid, 1'b1);
        chk("sat_sum", sum, 8'h80);
        chk("sat_ovf", ovf, 1'b1);
        chk("sat_c_out", c_out, 1'b0);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
